morse_tx_sequencer: RTL and testbench

- Scheduler between the PS/2 receive path and the single-bit Morse output pin.
- Pops PS/2 set-2 scancodes through a valid/ready handshake, filters break (release) sequences, and looks up the Morse pattern.
- Sequences mark and gap timing in integer "units" of UNIT_CYCLES clocks: dot, dash, and the symbol, letter and word gaps.
- One character is in flight at a time; upstream buffering absorbs typing bursts.

---
 rtl/morse_pkg.sv | 75 +++++++
 rtl/morse_tx_sequencer_if.sv | 22 ++
 rtl/morse_unit_timer.sv | 43 ++++
 rtl/morse_tx_sequencer.sv | 139 +++++++++++++
 tb/tb_morse_tx_sequencer.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse transmit sequencer: FSM encodings, unit counts
// and the PS/2 set-2 scancode to Morse pattern table.
package morse_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_LOOKUP   = 3'd1;
    localparam state_t ST_MARK     = 3'd2;
    localparam state_t ST_GAP_SYM  = 3'd3;
    localparam state_t ST_GAP_CHAR = 3'd4;
    localparam state_t ST_GAP_WORD = 3'd5;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] SPACE_CODE = 8'h29;

    localparam logic [2:0] DOT_UNITS        = 3'd1;
    localparam logic [2:0] DASH_UNITS       = 3'd3;
    localparam logic [2:0] SYM_GAP_UNITS    = 3'd1;
    localparam logic [2:0] CHAR_GAP_UNITS   = 3'd3;
    localparam logic [2:0] WORD_EXTRA_UNITS = 3'd4;

    typedef struct packed {
        logic       valid;
        logic [2:0] len;
        logic [4:0] pattern;
    } morse_entry_t;

    // Pattern is MSB-first, 1 = dash; only the top len bits are meaningful.
    function automatic morse_entry_t morse_lookup(input logic [7:0] code);
        morse_entry_t e;
        e = '0;
        case (code)
            8'h1C: e = {1'b1, 3'd2, 5'b01000}; // A
            8'h32: e = {1'b1, 3'd4, 5'b10000}; // B
            8'h21: e = {1'b1, 3'd4, 5'b10100}; // C
            8'h23: e = {1'b1, 3'd3, 5'b10000}; // D
            8'h24: e = {1'b1, 3'd1, 5'b00000}; // E
            8'h2B: e = {1'b1, 3'd4, 5'b00100}; // F
            8'h34: e = {1'b1, 3'd3, 5'b11000}; // G
            8'h33: e = {1'b1, 3'd4, 5'b00000}; // H
            8'h43: e = {1'b1, 3'd2, 5'b00000}; // I
            8'h3B: e = {1'b1, 3'd4, 5'b01110}; // J
            8'h42: e = {1'b1, 3'd3, 5'b10100}; // K
            8'h4B: e = {1'b1, 3'd4, 5'b01000}; // L
            8'h3A: e = {1'b1, 3'd2, 5'b11000}; // M
            8'h31: e = {1'b1, 3'd2, 5'b10000}; // N
            8'h44: e = {1'b1, 3'd3, 5'b11100}; // O
            8'h4D: e = {1'b1, 3'd4, 5'b01100}; // P
            8'h15: e = {1'b1, 3'd4, 5'b11010}; // Q
            8'h2D: e = {1'b1, 3'd3, 5'b01000}; // R
            8'h1B: e = {1'b1, 3'd3, 5'b00000}; // S
            8'h2C: e = {1'b1, 3'd1, 5'b10000}; // T
            8'h3C: e = {1'b1, 3'd3, 5'b00100}; // U
            8'h2A: e = {1'b1, 3'd4, 5'b00010}; // V
            8'h1D: e = {1'b1, 3'd3, 5'b01100}; // W
            8'h22: e = {1'b1, 3'd4, 5'b10010}; // X
            8'h35: e = {1'b1, 3'd4, 5'b10110}; // Y
            8'h1A: e = {1'b1, 3'd4, 5'b11000}; // Z
            8'h45: e = {1'b1, 3'd5, 5'b11111}; // 0
            8'h16: e = {1'b1, 3'd5, 5'b01111}; // 1
            8'h1E: e = {1'b1, 3'd5, 5'b00111}; // 2
            8'h26: e = {1'b1, 3'd5, 5'b00011}; // 3
            8'h25: e = {1'b1, 3'd5, 5'b00001}; // 4
            8'h2E: e = {1'b1, 3'd5, 5'b00000}; // 5
            8'h36: e = {1'b1, 3'd5, 5'b10000}; // 6
            8'h3D: e = {1'b1, 3'd5, 5'b11000}; // 7
            8'h3E: e = {1'b1, 3'd5, 5'b11100}; // 8
            8'h46: e = {1'b1, 3'd5, 5'b11110}; // 9
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/morse_tx_sequencer_if.sv
// Scancode intake handshake and Morse output bundle of the transmit sequencer.
interface morse_tx_sequencer_if;
    // A code transfers at a rising edge where code_valid & code_ready are both high;
    // code_ready does not depend on code_valid, and code_in is ignored while code_ready is low.
    logic [7:0] code_in;
    logic       code_valid;
    logic       code_ready;
    logic       morse_out;
    logic       busy;
    logic       drop_strb;
    logic [2:0] state_dbg;

    modport master (
        output code_in, code_valid,
        input  code_ready, morse_out, busy, drop_strb, state_dbg
    );

    modport slave (
        input  code_in, code_valid,
        output code_ready, morse_out, busy, drop_strb, state_dbg
    );
endinterface

// File: rtl/morse_unit_timer.sv
// Interval timer counting whole Morse units of UNIT_CYCLES clocks; done flags the
// last cycle of the interval started by the most recent load.
module morse_unit_timer #(
    parameter logic [23:0] UNIT_CYCLES = 24'd10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [2:0] units,
    output logic       done
);

    logic [23:0] cyc_q, cyc_d;
    logic [2:0]  unit_q, unit_d;

    always_comb begin
        cyc_d  = cyc_q;
        unit_d = unit_q;
        if (load) begin
            cyc_d  = UNIT_CYCLES - 24'd1;
            unit_d = units - 3'd1;
        end else if (cyc_q != 24'd0) begin
            cyc_d = cyc_q - 24'd1;
        end else if (unit_q != 3'd0) begin
            cyc_d  = UNIT_CYCLES - 24'd1;
            unit_d = unit_q - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q  <= 24'd0;
            unit_q <= 3'd0;
        end else begin
            cyc_q  <= cyc_d;
            unit_q <= unit_d;
        end
    end

    // Both counters hold at zero once expired, so done stays high until the next load.
    assign done = (cyc_q == 24'd0) && (unit_q == 3'd0);

endmodule

// File: rtl/morse_tx_sequencer.sv
// Pops PS/2 scancodes, filters break sequences and keys out one Morse character
// at a time with dot/dash/gap timing in units of UNIT_CYCLES clocks.
module morse_tx_sequencer
    import morse_pkg::*;
#(
    parameter logic [23:0] UNIT_CYCLES = 24'd10_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    morse_tx_sequencer_if.slave   bus
);

    state_t       state_q, state_d;
    logic [7:0]   code_q, code_d;
    logic         brk_q, brk_d;
    logic [4:0]   pat_q, pat_d;
    logic [2:0]   len_q, len_d;
    logic [2:0]   idx_q, idx_d;
    logic         morse_q, morse_d;
    logic         drop_q, drop_d;
    logic         tmr_load;
    logic [2:0]   tmr_units;
    logic         tmr_done;
    morse_entry_t entry;
    logic         accept;

    assign entry  = morse_lookup(code_q);
    // rst_n gates ready so it reads low throughout reset even though state is IDLE.
    assign bus.code_ready = rst_n & (state_q == ST_IDLE);
    assign accept         = bus.code_valid & bus.code_ready;

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        brk_d     = brk_q;
        pat_d     = pat_q;
        len_d     = len_q;
        idx_d     = idx_q;
        drop_d    = 1'b0;
        tmr_load  = 1'b0;
        tmr_units = DOT_UNITS;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    code_d  = bus.code_in;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (code_q == BREAK_CODE) begin
                    brk_d   = 1'b1;
                    drop_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (brk_q) begin
                    brk_d   = 1'b0;
                    drop_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (code_q == SPACE_CODE) begin
                    tmr_load  = 1'b1;
                    tmr_units = WORD_EXTRA_UNITS;
                    state_d   = ST_GAP_WORD;
                end else if (entry.valid) begin
                    pat_d     = entry.pattern;
                    len_d     = entry.len;
                    idx_d     = 3'd0;
                    tmr_load  = 1'b1;
                    tmr_units = entry.pattern[4] ? DASH_UNITS : DOT_UNITS;
                    state_d   = ST_MARK;
                end else begin
                    drop_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_MARK: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    if ((idx_q + 3'd1) < len_q) begin
                        tmr_units = SYM_GAP_UNITS;
                        state_d   = ST_GAP_SYM;
                    end else begin
                        tmr_units = CHAR_GAP_UNITS;
                        state_d   = ST_GAP_CHAR;
                    end
                end
            end
            ST_GAP_SYM: begin
                // pat_q[4] is always the element currently being keyed.
                if (tmr_done) begin
                    idx_d     = idx_q + 3'd1;
                    pat_d     = {pat_q[3:0], 1'b0};
                    tmr_load  = 1'b1;
                    tmr_units = pat_q[3] ? DASH_UNITS : DOT_UNITS;
                    state_d   = ST_MARK;
                end
            end
            ST_GAP_CHAR, ST_GAP_WORD: begin
                if (tmr_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        morse_d = (state_d == ST_MARK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            code_q  <= 8'h00;
            brk_q   <= 1'b0;
            pat_q   <= 5'd0;
            len_q   <= 3'd0;
            idx_q   <= 3'd0;
            morse_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            brk_q   <= brk_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            morse_q <= morse_d;
            drop_q  <= drop_d;
        end
    end

    morse_unit_timer #(.UNIT_CYCLES(UNIT_CYCLES)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .units (tmr_units),
        .done  (tmr_done)
    );

    assign bus.morse_out = morse_q;
    assign bus.drop_strb = drop_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_morse_tx_sequencer.sv
// Self-checking bench for morse_tx_sequencer with UNIT_CYCLES = 4: table-driven
// characters, a per-cycle expected-output queue, and hand-written reset sequences.
module tb_morse_tx_sequencer;

    localparam int UC = 4;

    // Expected entry per cycle: {morse_out, busy, code_ready, drop_strb}
    localparam logic [3:0] E_LOOKUP = 4'b0100;
    localparam logic [3:0] E_MARK   = 4'b1100;
    localparam logic [3:0] E_GAP    = 4'b0100;
    localparam logic [3:0] E_IDLE   = 4'b0010;
    localparam logic [3:0] E_DROP   = 4'b0011;

    typedef struct {
        logic [7:0] code;
        string      morse;   // dots/dashes, " " for word space, "x" for a dropped code
        bit         hold;    // keep code_valid high into the next send
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [3:0] exp_q[$];
    vec_t vecs[$];

    morse_tx_sequencer_if bus ();

    morse_tx_sequencer #(.UNIT_CYCLES(24'd4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog time=%0t required=finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            logic [3:0] e;
            logic [3:0] a;
            e = exp_q.pop_front();
            a = {bus.morse_out, bus.busy, bus.code_ready, bus.drop_strb};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL cycle_out t=%0t {morse,busy,ready,drop} got=%b want=%b", $time, a, e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_n(input logic [3:0] v, input int n);
        repeat (n) exp_q.push_back(v);
    endtask

    task automatic push_expect(input string m);
        exp_q.push_back(E_LOOKUP);
        if (m == "x") begin
            exp_q.push_back(E_DROP);
        end else if (m == " ") begin
            push_n(E_GAP, 4 * UC);
            exp_q.push_back(E_IDLE);
        end else begin
            for (int i = 0; i < m.len(); i++) begin
                push_n(E_MARK, (m.getc(i) == "-") ? 3 * UC : UC);
                push_n(E_GAP, (i == m.len() - 1) ? 3 * UC : UC);
            end
            exp_q.push_back(E_IDLE);
        end
    endtask

    task automatic send(input logic [7:0] code, input string m, input bit hold);
        int waited;
        waited = 0;
        @(negedge clk);
        bus.code_in    = code;
        bus.code_valid = 1'b1;
        while (!bus.code_ready && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!bus.code_ready) begin
            failures++;
            $display("FAIL accept_timeout code=%h ready=%b want=1", code, bus.code_ready);
            bus.code_valid = 1'b0;
        end else begin
            @(posedge clk);
            push_expect(m);
            #1;
            if (!hold) bus.code_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout left=%0d want=0", exp_q.size());
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s got=%b want=%b", name, act, want);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- test ----------------
    initial begin
        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        bus.code_in    = 8'h00;
        bus.code_valid = 1'b0;

        vecs.push_back('{8'h24, ".",     1'b0}); // E
        vecs.push_back('{8'h1C, ".-",    1'b0}); // A
        vecs.push_back('{8'h45, "-----", 1'b0}); // 0
        vecs.push_back('{8'h24, ".",     1'b1}); // E, held
        vecs.push_back('{8'h29, " ",     1'b1}); // space, held
        vecs.push_back('{8'h2C, "-",     1'b0}); // T
        vecs.push_back('{8'hF0, "x",     1'b0}); // break prefix
        vecs.push_back('{8'h24, "x",     1'b0}); // released E, discarded
        vecs.push_back('{8'h24, ".",     1'b0}); // E again, keyed
        vecs.push_back('{8'h00, "x",     1'b0}); // unmapped
        vecs.push_back('{8'hE0, "x",     1'b0}); // extended prefix, unmapped
        vecs.push_back('{8'h29, " ",     1'b0}); // space from idle
        vecs.push_back('{8'h15, "--.-",  1'b0}); // Q
        vecs.push_back('{8'h2E, ".....", 1'b0}); // 5
        vecs.push_back('{8'h1A, "--..",  1'b0}); // Z
        vecs.push_back('{8'h3B, ".---",  1'b0}); // J

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_bit("rst_ready", bus.code_ready, 1'b0);
        check_bit("rst_busy",  bus.busy,       1'b0);
        check_bit("rst_morse", bus.morse_out,  1'b0);
        check_bit("rst_drop",  bus.drop_strb,  1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_bit("post_rst_ready", bus.code_ready, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].code, vecs[i].morse, vecs[i].hold);
        end
        drain();

        // Reset in the middle of a dash must force outputs low without a clock edge
        send(8'h2C, "-", 1'b0);
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_bit("midmark_rst_morse", bus.morse_out,  1'b0);
        check_bit("midmark_rst_busy",  bus.busy,       1'b0);
        check_bit("midmark_rst_ready", bus.code_ready, 1'b0);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(8'h24, ".", 1'b0);
        drain();

        // Pending break must not survive reset
        send(8'hF0, "x", 1'b0);
        drain();
        do_reset();
        send(8'h24, ".", 1'b0);
        drain();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
